// File: rtl/modn_cascade_cnt.sv
// Cascaded modulo-MOD counter of DIGITS digits with up/down, clear, load and sticky overflow.
// Define CNT_SAT_EN to make the whole counter saturate at its terminal value instead of wrapping.
module modn_cascade_cnt #(
  parameter  int MOD    = 10,
  parameter  int DIGITS = 4,
  localparam int DW     = $clog2(MOD)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 up,
  input  logic                 sclr,
  input  logic                 ld,
  input  logic [DIGITS*DW-1:0] ld_val,
  output logic [DIGITS*DW-1:0] cnt,
  output logic                 inc_nxt,
  output logic                 ovf
);

  localparam logic [DW-1:0] MAX_V  = DW'(MOD - 32'sd1);
  localparam logic [DW-1:0] ZERO_V = {DW{1'b0}};
  localparam logic [DW-1:0] ONE_V  = DW'(32'd1);

  function automatic logic [DW-1:0] step_dig(input logic [DW-1:0] v, input logic dir_up);
    logic [DW-1:0] r;
    if (dir_up) begin
      if (v == MAX_V) r = ZERO_V;
      else            r = v + ONE_V;
    end else begin
      if (v == ZERO_V) r = MAX_V;
      else             r = v - ONE_V;
    end
    return r;
  endfunction

  // Out-of-range load fields become 0 so a digit can never hold a value >= MOD.
  function automatic logic [DW-1:0] clamp_dig(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    if (v > MAX_V) r = ZERO_V;
    else           r = v;
    return r;
  endfunction

  function automatic logic is_term(input logic [DW-1:0] v, input logic dir_up);
    logic r;
    if (dir_up) r = (v == MAX_V);
    else        r = (v == ZERO_V);
    return r;
  endfunction

  logic [DIGITS-1:0] term_s;
  logic [DIGITS:0]   chain_s;
  logic              all_term_s;
  logic              blocked_s;
  logic              ovf_r;
  logic              ovf_nxt_s;

  // Ripple enable: chain_s[i] is high when every digit below i is terminal.
  always_comb begin
    chain_s    = {(DIGITS+1){1'b0}};
    chain_s[0] = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      chain_s[i+1] = chain_s[i] & term_s[i];
    end
  end

  assign all_term_s = chain_s[DIGITS];
  assign inc_nxt    = en & all_term_s;

`ifdef CNT_SAT_EN
  assign blocked_s = all_term_s;
`else
  assign blocked_s = 1'b0;
`endif

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    logic [DW-1:0] dig_r;
    logic [DW-1:0] dig_nxt_s;

    assign term_s[i]          = is_term(dig_r, up);
    assign cnt[i*DW +: DW]    = dig_r;

    // Next digit value: clear beats load beats count.
    always_comb begin
      dig_nxt_s = dig_r;
      if (sclr) begin
        dig_nxt_s = ZERO_V;
      end else if (ld) begin
        dig_nxt_s = clamp_dig(ld_val[i*DW +: DW]);
      end else if (en && chain_s[i] && !blocked_s) begin
        dig_nxt_s = step_dig(dig_r, up);
      end else begin
        dig_nxt_s = dig_r;
      end
    end

    // Digit storage.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) dig_r <= ZERO_V;
      else        dig_r <= dig_nxt_s;
    end
  end

  // Overflow is sticky: set by any wrap (or blocked step when saturating), cleared only by sclr.
  always_comb begin
    ovf_nxt_s = ovf_r;
    if (sclr) begin
      ovf_nxt_s = 1'b0;
    end else if (ld) begin
      ovf_nxt_s = ovf_r;
    end else if (en && all_term_s) begin
      ovf_nxt_s = 1'b1;
    end else begin
      ovf_nxt_s = ovf_r;
    end
  end

  // Overflow flag storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_r <= 1'b0;
    else        ovf_r <= ovf_nxt_s;
  end

  assign ovf = ovf_r;

endmodule
